// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial N-bit subtractor: diff = (a - b - bin) mod 2^N, one bit per clock,
// LSB first, with a start/busy/done handshake. A single full-subtractor cell
// walks across shift-register copies of the operands.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> ovf port exists and reports signed overflow of the result
//   undefined -> no ovf port and no ovf register
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request, sampled only while idle
//   a      in   N  minuend, captured on the accepting edge
//   b      in   N  subtrahend, captured on the accepting edge
//   bin    in   1  borrow-in, captured on the accepting edge
//   busy   out  1  high while bits are being processed
//   done   out  1  one-cycle pulse; results valid from this cycle
//   diff   out  N  (a - b - bin) mod 2^N, held until the next operation ends
//   bout   out  1  unsigned borrow-out: 1 iff a < b + bin
//   ovf    out  1  signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    a_sr;
    logic [N-1:0]    b_sr;
    logic [N-1:0]    res_sr;
    logic [N-1:0]    res_next;
    logic            br;
    logic            br_next;
    logic            x;
    logic            y;
    logic            d;
    logic            last_bit;
    logic [CW-1:0]   cnt;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    // NOTE: every signal driven here gets a value before any conditional use,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        x        = a_sr[0];
        y        = b_sr[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        // New result bit enters from the MSB side; after N shifts bit 0 of
        // the operands has landed in bit 0 of the result.
        res_next         = res_sr >> 1;
        res_next[N-1]    = d;
        last_bit = (cnt == CW'(N - 1));
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so requests during
    // RUN or DONE are simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Datapath: operand/result shift registers, borrow flop, bit counter and
    // the held output registers.
    // NOTE: all datapath registers, including the shift registers, are
    // reset so a reset mid-operation leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    // Publish on the final bit so outputs change on the same
                    // edge that raises done.
                    if (last_bit) begin
                        diff <= res_next;
                        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // br is the borrow into bit N-1, br_next the borrow
                        // out of it; they differ exactly on signed overflow.
                        ovf  <= br ^ br_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor. Stimulus pushes the expected result
// (computed with plain integer arithmetic) into a queue; an independent
// monitor pops and compares whenever done is seen. A second instance with
// N=1 covers the single-bit corner case.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         bin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         bout1;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.N(N)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor #(.N(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   busy_run  = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: plain integer subtraction, unsigned and signed views.
    function automatic exp_t model(input int av, input int bv, input int binv, input int acc);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        int   sr;
        r      = av - bv - binv;
        e.diff = r[N-1:0];
        e.bout = (r < 0);
        sa     = (av >= (1 << (N - 1))) ? av - (1 << N) : av;
        sb     = (bv >= (1 << (N - 1))) ? bv - (1 << N) : bv;
        sr     = sa - sb - binv;
        e.ovf  = (sr < -(1 << (N - 1))) || (sr > (1 << (N - 1)) - 1);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("busy_done_exclusive", busy, 1'b0);
                check("done_single_pulse", prev_done, 1'b0);
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("diff", diff, mon_e.diff);
                    check("bout", bout, mon_e.bout);
`ifdef SERIAL_SUB_OVF_EN
                    check("ovf", ovf, mon_e.ovf);
`endif
                    // Accept edge k, done visible after edge k+N (N+1 edges).
                    check("latency", cyc - mon_e.acc, N);
                    check("busy_cycles", busy_run, N);
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    // Drive one request from idle; the next edge accepts it.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic binv);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = binv;
        @(posedge clk);
        #1;
        exp_q.push_back(model(int'(av), int'(bv), int'(binv), cyc));
        start = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard is empty, then until DUT is idle.
    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] tab_a   [9] = '{8'h5A, 8'h00, 8'h10, 8'hFF, 8'h80, 8'h7F, 8'h05, 8'hC3, 8'h01};
    logic [N-1:0] tab_b   [9] = '{8'h21, 8'h01, 8'h10, 8'hFF, 8'h01, 8'hFF, 8'h03, 8'h3C, 8'h00};
    logic         tab_bin [9] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        bin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        bin1   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_n1_diff", diff1, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic, wrap-around, overflow and borrow-in vectors.
        for (int i = 0; i < 9; i++) begin
            issue(tab_a[i], tab_b[i], tab_bin[i]);
            wait_drain("table");
        end

        // start pulses in RUN (cycle 3) and DONE (cycle 9) must be ignored.
        issue(8'h80, 8'h01, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("ignored_start_pending", exp_q.size(), 0);
        check("ignored_start_hold", diff, 8'h7F);

        // Reset in the fourth RUN cycle: outputs clear at once, no done.
        @(posedge clk);
        #1;
        issue(8'h55, 8'h12, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrun_reset_diff", diff, 0);
        check("midrun_reset_bout", bout, 0);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrun_reset_ovf", ovf, 0);
`endif
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(8'h03, 8'h01, 1'b0);
        wait_drain("post_reset");

        // Back-to-back with start held: one accept every N+2 edges.
        for (int i = 0; i < 1000; i++) begin
            start = 1'b1;
            a     = N'($urandom);
            b     = N'($urandom);
            bin   = 1'($urandom);
            @(posedge clk);
            #1;
            exp_q.push_back(model(int'(a), int'(b), int'(bin), cyc));
            repeat (N + 1) @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_drain("back_to_back");

        // N=1 instance: 1 - 1 - 1 wraps to 1 with a borrow out.
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        bin1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        check("n1_busy_cycle1", busy1, 1'b1);
        check("n1_done_cycle1", done1, 1'b0);
        @(negedge clk);
        check("n1_busy_cycle2", busy1, 1'b0);
        check("n1_done_cycle2", done1, 1'b1);
        check("n1_diff", diff1, 1'b1);
        check("n1_bout", bout1, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        check("n1_ovf", ovf1, 1'b0);
`endif
        @(negedge clk);
        check("n1_done_pulse", done1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
